// File: rtl/stream_join_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stream_join_n                                                |
// | Description : N-way stream join. Each branch feeds its own FIFO; a joined  |
// |               beat (the heads of all FIFOs) is offered whenever every FIFO |
// |               holds data. Adds sync flush, occupancy outputs, a sticky     |
// |               sustained-skew error and a free-running join counter.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stream_join_n #(
   parameter int NUM_BR     = 2,
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 4,
   parameter int SKEW_LIMIT = 64,
   localparam int OCC_W     = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic [NUM_BR-1:0]          br_valid,
   output logic [NUM_BR-1:0]          br_ready,
   input  logic [NUM_BR*DATA_W-1:0]   br_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_BR*DATA_W-1:0]   out_data,
   output logic [NUM_BR*OCC_W-1:0]    occ,
   output logic                       skew_err,
   output logic [31:0]                join_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [NUM_BR-1:0]        w_full;
   logic [NUM_BR-1:0]        w_empty;
   logic [NUM_BR-1:0]        w_push;
   logic                     w_pop;
   logic [NUM_BR*DATA_W-1:0] w_head;
   logic [31:0]              r_join_count;

   // A joined beat exists only when every branch has contributed its k-th beat.
   assign out_valid = ~|w_empty;
   // Flush discards the pop, so out_ready is ignored in that cycle.
   assign w_pop     = out_valid & out_ready & ~flush;
   // A full FIFO can still accept when its head leaves in the same cycle.
   assign br_ready  = flush ? '0 : (~w_full | {NUM_BR{w_pop}});
   assign w_push    = br_valid & br_ready;
   assign out_data  = out_valid ? w_head : '0;

   // ---------------------------------------------------------------------------
   // Per-branch FIFO with explicit occupancy so full/empty need no extra ptr bit
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < NUM_BR; i++) begin : g_br
      logic [DATA_W-1:0] r_mem [DEPTH];
      logic [PTR_W-1:0]  r_wr_ptr;
      logic [PTR_W-1:0]  r_rd_ptr;
      logic [OCC_W-1:0]  r_count;

      assign w_full[i]  = (r_count == OCC_W'(DEPTH));
      assign w_empty[i] = (r_count == '0);
      assign w_head[i*DATA_W +: DATA_W] = r_mem[r_rd_ptr];
      assign occ[i*OCC_W +: OCC_W]      = r_count;

      // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push[i]) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push[i] && !w_pop)      r_count <= r_count + OCC_W'(1);
            else if (!w_push[i] && w_pop) r_count <= r_count - OCC_W'(1);
         end
      end

      // Payload storage; contents are don't-care while empty because out_data is gated.
      always_ff @(posedge clk) begin
         if (w_push[i]) r_mem[r_wr_ptr] <= br_data[i*DATA_W +: DATA_W];
      end
   end

   // ---------------------------------------------------------------------------
   // Sustained-skew monitor: some branch full while another is starved
   // ---------------------------------------------------------------------------
   if (SKEW_LIMIT > 0) begin : g_skew
      localparam int CNT_W = $clog2(SKEW_LIMIT + 1);
      logic             w_skewed;
      logic [CNT_W-1:0] r_skew_cnt;
      logic             r_skew_err;

      // A FIFO cannot be both full and empty, so the two flags imply distinct branches.
      assign w_skewed = (|w_full) & (|w_empty);
      assign skew_err = r_skew_err;

      // Count consecutive skewed cycles, saturate at the limit, latch the error.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_skew_cnt <= '0;
            r_skew_err <= 1'b0;
         end else if (flush) begin
            r_skew_cnt <= '0;
            r_skew_err <= 1'b0;
         end else if (w_skewed) begin
            if (r_skew_cnt != CNT_W'(SKEW_LIMIT)) r_skew_cnt <= r_skew_cnt + CNT_W'(1);
            if (r_skew_cnt >= CNT_W'(SKEW_LIMIT - 1)) r_skew_err <= 1'b1;
         end else begin
            r_skew_cnt <= '0;
         end
      end
   end else begin : g_no_skew
      assign skew_err = 1'b0;
   end

   // Joined-beat counter; survives flush and wraps modulo 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_join_count <= '0;
      else if (w_pop) r_join_count <= r_join_count + 32'd1;
   end

   assign join_count = r_join_count;

endmodule
`default_nettype wire

// File: tb/tb_stream_join_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stream_join_n                                             |
// | Description : Self-checking bench for stream_join_n (2 branches, depth 4,  |
// |               skew limit 8). Directed scenarios plus random traffic, all   |
// |               compared against a queue-based reference model.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_stream_join_n;

   localparam int NB    = 2;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;
   localparam int OCC_W = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic [NB-1:0]     br_valid;
   logic [NB-1:0]     br_ready;
   logic [NB*DW-1:0]  br_data;
   logic              out_valid;
   logic              out_ready;
   logic [NB*DW-1:0]  out_data;
   logic [NB*OCC_W-1:0] occ;
   logic              skew_err;
   logic [31:0]       join_count;

   stream_join_n #(.NUM_BR(NB), .DATA_W(DW), .DEPTH(DEPTH), .SKEW_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .br_valid(br_valid), .br_ready(br_ready), .br_data(br_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occ(occ), .skew_err(skew_err), .join_count(join_count)
   );

   always #5 clk = ~clk;

   // Reference model: one queue per branch, plus skew and join bookkeeping.
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   int          m_skew_cnt;
   bit          m_skew_err;
   logic [31:0] m_join;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      m_skew_cnt = 0;
      m_skew_err = 1'b0;
   endtask

   // One clock cycle: drive at negedge, compare against the model, advance model at posedge.
   task automatic cycle(input bit f, input logic [1:0] v, input logic [63:0] d, input bit rdy);
      bit          e_valid, e_pop, skewed;
      logic [1:0]  e_rdy;
      logic [63:0] e_data;
      int          s0, s1;
      @(negedge clk);
      flush = f; br_valid = v; br_data = d; out_ready = rdy;
      #1;
      s0 = q0.size();
      s1 = q1.size();
      e_valid = (s0 > 0) && (s1 > 0);
      e_data  = e_valid ? {q1[0], q0[0]} : 64'd0;
      e_pop   = e_valid && rdy && !f;
      e_rdy[0] = !f && ((s0 < DEPTH) || e_pop);
      e_rdy[1] = !f && ((s1 < DEPTH) || e_pop);
      check("out_valid",  {63'd0, out_valid}, {63'd0, e_valid});
      check("out_data",   out_data, e_data);
      check("br_ready",   {62'd0, br_ready}, {62'd0, e_rdy});
      check("occ",        {58'd0, occ}, {58'd0, 3'(s1), 3'(s0)});
      check("skew_err",   {63'd0, skew_err}, {63'd0, m_skew_err});
      check("join_count", {32'd0, join_count}, {32'd0, m_join});
      skewed = ((s0 == DEPTH) || (s1 == DEPTH)) && ((s0 == 0) || (s1 == 0));
      @(posedge clk);
      if (f) begin
         model_clear();
      end else begin
         if (e_pop) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
            m_join = m_join + 32'd1;
         end
         if (v[0] && e_rdy[0]) q0.push_back(d[31:0]);
         if (v[1] && e_rdy[1]) q1.push_back(d[63:32]);
         if (skewed) begin
            m_skew_cnt = (m_skew_cnt + 1 > LIMIT) ? LIMIT : m_skew_cnt + 1;
            if (m_skew_cnt == LIMIT) m_skew_err = 1'b1;
         end else begin
            m_skew_cnt = 0;
         end
      end
   endtask

   // Registered outputs are stable shortly after the edge.
   task automatic after();
      #2;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      rst_n = 1'b0; flush = 1'b0; br_valid = '0; br_data = '0; out_ready = 1'b0;
      model_clear();
      m_join = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {63'd0, out_valid}, 64'd0);
      check("rst_occ",   {58'd0, occ}, 64'd0);
      check("rst_ready", {62'd0, br_ready}, 64'd3);
      check("rst_join",  {32'd0, join_count}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Scenario 1: A on br0 at t, B on br1 at t+3, joined at t+4.
      cycle(0, 2'b01, {32'd0, 32'h0001_0000}, 1);
      cycle(0, 2'b00, 64'd0, 1);
      cycle(0, 2'b00, 64'd0, 1);
      cycle(0, 2'b10, {32'hFFFF_0000, 32'd0}, 1);
      after();
      check("t1_valid_t4", {63'd0, out_valid}, 64'd1);
      check("t1_data",     out_data, {32'hFFFF_0000, 32'h0001_0000});
      cycle(0, 2'b00, 64'd0, 1);
      after();
      check("t1_join", {32'd0, join_count}, 64'd1);

      // Scenario 2: br0 alone fills; 5th push held; br1 beat releases one join.
      for (int k = 0; k < 4; k++) cycle(0, 2'b01, rnd64(), 1);
      after();
      check("t2_occ0",  {61'd0, occ[2:0]}, 64'd4);
      check("t2_valid", {63'd0, out_valid}, 64'd0);
      cycle(0, 2'b01, rnd64(), 1);
      cycle(0, 2'b10, rnd64(), 1);
      cycle(0, 2'b01, rnd64(), 1);
      after();
      check("t2_join", {32'd0, join_count}, 64'd2);
      check("t2_occ0b", {61'd0, occ[2:0]}, 64'd4);

      // Scenario 3: both full, sustained push+pop for 20 cycles.
      cycle(1, 2'b00, 64'd0, 0);
      for (int k = 0; k < 4; k++) cycle(0, 2'b11, rnd64(), 0);
      for (int k = 0; k < 20; k++) cycle(0, 2'b11, rnd64(), 1);
      after();
      check("t3_occ",  {58'd0, occ}, {58'd0, 3'd4, 3'd4});
      check("t3_join", {32'd0, join_count}, 64'd22);

      // Scenario 4: br0 full, br1 empty -> sticky skew error after 8 skewed cycles.
      cycle(1, 2'b00, 64'd0, 0);
      for (int k = 0; k < 4; k++) cycle(0, 2'b01, rnd64(), 1);
      for (int k = 0; k < 7; k++) cycle(0, 2'b00, 64'd0, 1);
      after();
      check("t4_skew_7", {63'd0, skew_err}, 64'd0);
      cycle(0, 2'b00, 64'd0, 1);
      after();
      check("t4_skew_8", {63'd0, skew_err}, 64'd1);
      cycle(0, 2'b10, rnd64(), 0);
      after();
      check("t4_skew_hold", {63'd0, skew_err}, 64'd1);
      cycle(1, 2'b00, 64'd0, 0);
      after();
      check("t4_skew_clr", {63'd0, skew_err}, 64'd0);
      check("t4_occ_clr",  {58'd0, occ}, 64'd0);

      // Scenario 5: flush with a pop pending and pushes active.
      cycle(0, 2'b11, rnd64(), 0);
      cycle(1, 2'b11, rnd64(), 1);
      after();
      check("t5_join", {32'd0, join_count}, 64'd22);
      check("t5_occ",  {58'd0, occ}, 64'd0);

      // Random traffic with occasional flushes.
      for (int k = 0; k < 1500; k++)
         cycle(($urandom_range(0, 49) == 0), 2'($urandom()), rnd64(),
               ($urandom_range(0, 3) != 0));

      // Scenario 6: async reset mid-burst with occ = {3,2}.
      cycle(1, 2'b00, 64'd0, 0);
      cycle(0, 2'b11, rnd64(), 0);
      cycle(0, 2'b11, rnd64(), 0);
      cycle(0, 2'b01, rnd64(), 0);
      after();
      check("t6_pre_occ", {58'd0, occ}, {58'd0, 3'd2, 3'd3});
      @(negedge clk);
      br_valid = 2'b11; out_ready = 1'b1; br_data = rnd64();
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_valid", {63'd0, out_valid}, 64'd0);
      check("t6_data",  out_data, 64'd0);
      check("t6_occ",   {58'd0, occ}, 64'd0);
      check("t6_skew",  {63'd0, skew_err}, 64'd0);
      check("t6_join",  {32'd0, join_count}, 64'd0);
      check("t6_ready", {62'd0, br_ready}, 64'd3);
      br_valid = '0; out_ready = 1'b0;
      model_clear();
      m_join = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;

      // Join counter wrap from 0xFFFFFFFF.
      @(negedge clk);
      force dut.r_join_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_join_count;
      m_join = 32'hFFFF_FFFF;
      cycle(0, 2'b11, rnd64(), 0);
      cycle(0, 2'b00, 64'd0, 1);
      after();
      check("t6_wrap", {32'd0, join_count}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
